branch_predict_resolve: RTL and testbench
=========================================

// Module: branch_predict_resolve
// PURPOSE
//   Parametrised successor to the ID-stage branch comparator: resolves conditional/unconditional branches,
//   traps and exceptions, and adds a direct-mapped branch history table (BHT) of saturating counters.
//   Sits between IF (prediction lookup) and ID/EX (resolution). Drives registered mispredict/flush signals
//   to the PC-select and pipeline-flush logic.
// PARAMETERS
//   DATA_W       32  operand width for resolution compares (signed)
//   PC_W         32  PC width; BHT index = pc[IDX_W+1:2], IDX_W = $clog2(BHT_ENTRIES)
//   BHT_ENTRIES  64  BHT depth; power of two, >= 2
//   CTR_W        2   counter width; taken when counter MSB = 1
//   STAT_W       16  mispredict statistics counter width
// PORTS
//   clk            in   1       core clock, all state on rising edge
//   rst            in   1       asynchronous, active-low reset
//   pred_valid_i   in   1       IF lookup request this cycle
//   pred_pc_i      in   PC_W    PC of fetched instruction
//   pred_taken_o   out  1       registered prediction for last accepted lookup
//   pred_vld_o     out  1       pred_taken_o valid (1 cycle after pred_valid_i)
//   res_valid_i    in   1       branch/trap/exception resolves this cycle
//   res_pc_i       in   PC_W    PC of resolving instruction
//   res_cond_i     in   3       condition code (see BEHAVIOUR)
//   res_a_i        in   DATA_W  operand rs
//   res_b_i        in   DATA_W  operand rt
//   res_pred_i     in   1       prediction that was used for this instruction
//   exception_i    in   1       exception pending at resolution point
//   res_taken_o    out  1       registered actual outcome
//   mispredict_o   out  1       registered: outcome != res_pred_i, or exception
//   flush_o        out  1       registered one-cycle pulse: flush younger stages
//   mispred_cnt_o  out  STAT_W  saturating count of mispredicts since reset
// BEHAVIOUR
//   - Reset (rst=0, async): every BHT entry = 2^(CTR_W-1)-1 (weakly not-taken); all outputs 0.
//   - Lookup: pred_valid_i=1 at edge N -> pred_vld_o=1, pred_taken_o=MSB of entry at edge N+1; else pred_vld_o=0.
//   - Cond codes: 0 EQ a==b; 1 NE a!=b; 2 GEZ a>=0; 3 LTZ a<0; 4 GTZ a>0; 5 LEZ a<=0;
//     6 ALWAYS (j/jal/jr/jalr) taken; 7 TEQ a==b. All sign compares on DATA_W bits.
//   - Resolution, res_valid_i=1 at edge N -> at N+1: res_taken_o=outcome; mispredict_o=(outcome!=res_pred_i);
//     flush_o=mispredict_o; when res_valid_i=0 these three are 0 at N+1 (single-cycle pulses).
//   - exception_i=1 (with or without res_valid_i): res_taken_o=1, mispredict_o=1, flush_o=1; no BHT update;
//     exception has priority over any condition result.
//   - BHT update (conditional codes 0-5 only, no exception): outcome taken -> counter+1, saturate at all-ones;
//     not-taken -> counter-1, saturate at 0. Codes 6,7 never update BHT.
//   - Same-index lookup and update in one cycle: lookup returns the post-update counter MSB (bypass).
//   - Index aliasing allowed; no tags.
//   - mispred_cnt_o increments on each mispredict_o pulse, holds at all-ones (no wrap).
//   - Reset asserted mid-operation: all state cleared immediately; pending pulses lost.
// STRUCTURE
//   - Shared defines header: cond-code constants COND_EQ..COND_TEQ, RST_ENABLED active-low value.
//   - Sub-module bht_counter_array: BHT_ENTRIES x CTR_W saturating counters, one read port,
//     one write port, internal write-to-read bypass.
//   - Top: condition evaluator (combinational), output registers, statistics counter.
// TESTING
//   1 Reset release -> 64 lookups of distinct PCs return pred_taken_o=0; mispred_cnt_o=0.
//   2 pc=0x40, cond EQ, a=b=5, pred=0 twice -> mispredict_o pulses twice, entry reaches 3, next lookup taken=1.
//   3 cond GEZ a=0x80000000 (neg) pred=0 -> res_taken_o=0, mispredict_o=0; GTZ a=1 pred=1 -> no flush.
//   4 Lookup and update same pc=0x100 same cycle, entry=1, taken -> pred_taken_o=1 next cycle (bypass).
//   5 exception_i=1 with cond NE a!=b pred=1 -> flush_o=1, BHT entry unchanged.
//   6 STAT_W=4: 20 forced mispredicts -> mispred_cnt_o=15 held; async rst=0 mid-burst -> all outputs 0 same cycle.

Source files
------------

// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch resolver: condition codes, reset level
// and the rule that decides which condition codes train the history table.
package branch_predict_resolve_pkg;

   typedef enum logic [2:0] {
      COND_EQ     = 3'd0,
      COND_NE     = 3'd1,
      COND_GEZ    = 3'd2,
      COND_LTZ    = 3'd3,
      COND_GTZ    = 3'd4,
      COND_LEZ    = 3'd5,
      COND_ALWAYS = 3'd6,
      COND_TEQ    = 3'd7
   } cond_e;

   localparam logic RST_ENABLED = 1'b0;

   // Jumps and trap compares never train the predictor.
   function automatic logic cond_updates_bht(input logic [2:0] cond);
      return (cond <= 3'(COND_LEZ));
   endfunction

endpackage

// File: rtl/branch_predict_resolve_bht_counter_array.sv
// Direct-mapped table of saturating counters. One read port and one update
// port; a same-index update is forwarded to the read port in the same cycle.
module branch_predict_resolve_bht_counter_array
   import branch_predict_resolve_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int CTR_W   = 2,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_msb,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;

   logic [CTR_W-1:0] ctr_q [ENTRIES];
   logic [CTR_W-1:0] wr_cur;
   logic [CTR_W-1:0] wr_next;

   always_comb begin
      wr_cur  = ctr_q[wr_idx];
      wr_next = wr_cur;
      if (wr_taken) begin
         if (wr_cur != CTR_MAX) wr_next = wr_cur + 1'b1;
      end else begin
         if (wr_cur != '0) wr_next = wr_cur - 1'b1;
      end
   end

   always_comb begin
      if (wr_en && (wr_idx == rd_idx)) rd_msb = wr_next[CTR_W-1];
      else                             rd_msb = ctr_q[rd_idx][CTR_W-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLED) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      end else if (wr_en) begin
         ctr_q[wr_idx] <= wr_next;
      end
   end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch/trap resolver with BHT prediction lookup; all outcome signals are
// registered single-cycle pulses toward PC-select and flush logic.
module branch_predict_resolve
   import branch_predict_resolve_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int PC_W        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_W       = 2,
   parameter int STAT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_valid_i,
   input  logic [PC_W-1:0]   pred_pc_i,
   output logic              pred_taken_o,
   output logic              pred_vld_o,
   input  logic              res_valid_i,
   input  logic [PC_W-1:0]   res_pc_i,
   input  logic [2:0]        res_cond_i,
   input  logic [DATA_W-1:0] res_a_i,
   input  logic [DATA_W-1:0] res_b_i,
   input  logic              res_pred_i,
   input  logic              exception_i,
   output logic              res_taken_o,
   output logic              mispredict_o,
   output logic              flush_o,
   output logic [STAT_W-1:0] mispred_cnt_o
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic             cond_taken;
   logic             a_neg;
   logic             a_zero;
   logic             mis_next;
   logic             bht_wr;
   logic             lookup_msb;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             unused_pc_bits;

   // Instructions are word aligned and the table is untagged.
   assign rd_idx = pred_pc_i[IDX_W+1:2];
   assign wr_idx = res_pc_i[IDX_W+1:2];
   assign unused_pc_bits = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0],
                             res_pc_i[PC_W-1:IDX_W+2], res_pc_i[1:0]};

   assign a_neg  = res_a_i[DATA_W-1];
   assign a_zero = (res_a_i == '0);

   always_comb begin
      cond_taken = 1'b0;
      case (cond_e'(res_cond_i))
         COND_EQ:     cond_taken = (res_a_i == res_b_i);
         COND_NE:     cond_taken = (res_a_i != res_b_i);
         COND_GEZ:    cond_taken = ~a_neg;
         COND_LTZ:    cond_taken = a_neg;
         COND_GTZ:    cond_taken = ~a_neg & ~a_zero;
         COND_LEZ:    cond_taken = a_neg | a_zero;
         COND_ALWAYS: cond_taken = 1'b1;
         COND_TEQ:    cond_taken = (res_a_i == res_b_i);
         default:     cond_taken = 1'b0;
      endcase
   end

   // An exception overrides the compare result and always redirects.
   assign mis_next = exception_i | (res_valid_i & (cond_taken != res_pred_i));
   assign bht_wr   = res_valid_i & ~exception_i & cond_updates_bht(res_cond_i);

   branch_predict_resolve_bht_counter_array #(
      .ENTRIES (BHT_ENTRIES),
      .CTR_W   (CTR_W),
      .IDX_W   (IDX_W)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (rd_idx),
      .rd_msb   (lookup_msb),
      .wr_en    (bht_wr),
      .wr_idx   (wr_idx),
      .wr_taken (cond_taken)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLED) begin
         pred_vld_o    <= 1'b0;
         pred_taken_o  <= 1'b0;
         res_taken_o   <= 1'b0;
         mispredict_o  <= 1'b0;
         flush_o       <= 1'b0;
         mispred_cnt_o <= '0;
      end else begin
         pred_vld_o   <= pred_valid_i;
         pred_taken_o <= pred_valid_i & lookup_msb;
         res_taken_o  <= exception_i | (res_valid_i & cond_taken);
         mispredict_o <= mis_next;
         flush_o      <= mis_next;
         if (mis_next && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench: directed corner sequences, a condition-code vector
// table and randomized traffic, all compared against a behavioural model.
module tb_branch_predict_resolve;

   localparam int STAT_W = 4;
   localparam int STAT_MAX = (1 << STAT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              pred_valid_i = 1'b0;
   logic [31:0]       pred_pc_i = '0;
   logic              pred_taken_o;
   logic              pred_vld_o;
   logic              res_valid_i = 1'b0;
   logic [31:0]       res_pc_i = '0;
   logic [2:0]        res_cond_i = '0;
   logic [31:0]       res_a_i = '0;
   logic [31:0]       res_b_i = '0;
   logic              res_pred_i = 1'b0;
   logic              exception_i = 1'b0;
   logic              res_taken_o;
   logic              mispredict_o;
   logic              flush_o;
   logic [STAT_W-1:0] mispred_cnt_o;

   int checks = 0;
   int failures = 0;

   int bht_m [64];
   int cnt_m;
   bit e_vld, e_pt, e_taken, e_mis;

   typedef struct {
      logic        rv;
      logic [2:0]  cond;
      logic [31:0] a;
      logic [31:0] b;
      logic        pred;
      logic        exc;
      logic        e_taken;
      logic        e_mis;
   } vec_t;

   vec_t vecs [16];

   always #5 clk = ~clk;

   branch_predict_resolve #(
      .DATA_W(32), .PC_W(32), .BHT_ENTRIES(64), .CTR_W(2), .STAT_W(STAT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pred_valid_i  (pred_valid_i),
      .pred_pc_i     (pred_pc_i),
      .pred_taken_o  (pred_taken_o),
      .pred_vld_o    (pred_vld_o),
      .res_valid_i   (res_valid_i),
      .res_pc_i      (res_pc_i),
      .res_cond_i    (res_cond_i),
      .res_a_i       (res_a_i),
      .res_b_i       (res_b_i),
      .res_pred_i    (res_pred_i),
      .exception_i   (exception_i),
      .res_taken_o   (res_taken_o),
      .mispredict_o  (mispredict_o),
      .flush_o       (flush_o),
      .mispred_cnt_o (mispred_cnt_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit eval_cond(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      int sa;
      sa = $signed(a);
      case (c)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd2: return sa >= 0;
         3'd3: return sa < 0;
         3'd4: return sa > 0;
         3'd5: return sa <= 0;
         3'd6: return 1'b1;
         default: return a == b;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) bht_m[i] = 1;
      cnt_m = 0;
      e_vld = 0; e_pt = 0; e_taken = 0; e_mis = 0;
   endtask

   // Update the table first so a same-index lookup sees the new counter.
   task automatic model_edge();
      bit outcome;
      int ri, pi;
      ri = int'((res_pc_i >> 2) & 32'h3F);
      pi = int'((pred_pc_i >> 2) & 32'h3F);
      e_taken = 0; e_mis = 0;
      if (exception_i) begin
         e_taken = 1; e_mis = 1;
      end else if (res_valid_i) begin
         outcome = eval_cond(res_cond_i, res_a_i, res_b_i);
         e_taken = outcome;
         e_mis = (outcome != res_pred_i);
         if (res_cond_i <= 3'd5) begin
            if (outcome) bht_m[ri] = (bht_m[ri] < 3) ? bht_m[ri] + 1 : 3;
            else         bht_m[ri] = (bht_m[ri] > 0) ? bht_m[ri] - 1 : 0;
         end
      end
      if (e_mis && cnt_m < STAT_MAX) cnt_m++;
      e_vld = pred_valid_i;
      e_pt = pred_valid_i && (bht_m[pi] >= 2);
   endtask

   task automatic check_all();
      chk("pred_vld", 32'(pred_vld_o), 32'(e_vld));
      if (e_vld) chk("pred_taken", 32'(pred_taken_o), 32'(e_pt));
      chk("res_taken", 32'(res_taken_o), 32'(e_taken));
      chk("mispredict", 32'(mispredict_o), 32'(e_mis));
      chk("flush", 32'(flush_o), 32'(e_mis));
      chk("mispred_cnt", 32'(mispred_cnt_o), 32'(cnt_m));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      pred_valid_i = 0; res_valid_i = 0; exception_i = 0; res_pred_i = 0;
      res_cond_i = 0; res_a_i = 0; res_b_i = 0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_pred_vld"}, 32'(pred_vld_o), 0);
      chk({tag, "_res_taken"}, 32'(res_taken_o), 0);
      chk({tag, "_mispredict"}, 32'(mispredict_o), 0);
      chk({tag, "_flush"}, 32'(flush_o), 0);
      chk({tag, "_cnt"}, 32'(mispred_cnt_o), 0);
   endtask

   task automatic apply_reset();
      idle();
      rst = 0;
      #1;
      check_zero("reset");
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1;
   endtask

   task automatic set_res(input logic [31:0] pc, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic pred, input logic exc);
      res_valid_i = 1; res_pc_i = pc; res_cond_i = c; res_a_i = a; res_b_i = b;
      res_pred_i = pred; exception_i = exc;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 3'd0, 32'd5,        32'd5, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 3'd0, 32'd5,        32'd6, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 3'd1, 32'd3,        32'd4, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[3]  = '{1'b1, 3'd2, 32'd0,        32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 3'd3, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 3'd3, 32'd0,        32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 3'd4, 32'd0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 3'd4, 32'd1,        32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 3'd5, 32'd0,        32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 3'd5, 32'd1,        32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 3'd6, 32'd9,        32'd3, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 3'd7, 32'd7,        32'd7, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[13] = '{1'b1, 3'd7, 32'd7,        32'd8, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 3'd0, 32'd1,        32'd2, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[15] = '{1'b0, 3'd0, 32'd1,        32'd1, 1'b1, 1'b0, 1'b0, 1'b0};

      #2;
      apply_reset();

      // Fresh table: every entry weakly not-taken.
      for (int i = 0; i < 64; i++) begin
         idle();
         pred_valid_i = 1; pred_pc_i = 32'(i * 4);
         cyc();
         chk("t1_lookup", 32'(pred_taken_o), 0);
      end
      chk("t1_cnt", 32'(mispred_cnt_o), 0);

      // Same-index update forwards into the lookup.
      idle();
      pred_valid_i = 1; pred_pc_i = 32'h100;
      set_res(32'h100, 3'd0, 32'd1, 32'd1, 1'b0, 1'b0);
      cyc();
      chk("t4_bypass", 32'(pred_taken_o), 1);

      // Exception redirects but leaves the counter alone.
      idle();
      set_res(32'h80, 3'd1, 32'd1, 32'd2, 1'b1, 1'b1);
      cyc();
      chk("t5_flush", 32'(flush_o), 1);
      chk("t5_taken", 32'(res_taken_o), 1);
      idle();
      pred_valid_i = 1; pred_pc_i = 32'h80;
      cyc();
      chk("t5_entry", 32'(pred_taken_o), 0);

      // Two taken EQ resolutions saturate the entry.
      for (int k = 0; k < 2; k++) begin
         idle();
         set_res(32'h40, 3'd0, 32'd5, 32'd5, 1'b0, 1'b0);
         cyc();
         chk("t2_mispredict", 32'(mispredict_o), 1);
         idle();
         cyc();
         chk("t2_pulse_end", 32'(mispredict_o), 0);
      end
      pred_valid_i = 1; pred_pc_i = 32'h40;
      cyc();
      chk("t2_lookup", 32'(pred_taken_o), 1);

      idle();
      set_res(32'h20, 3'd2, 32'h80000000, 32'd0, 1'b0, 1'b0);
      cyc();
      chk("t3_gez_taken", 32'(res_taken_o), 0);
      chk("t3_gez_mis", 32'(mispredict_o), 0);
      set_res(32'h24, 3'd4, 32'd1, 32'd0, 1'b1, 1'b0);
      cyc();
      chk("t3_gtz_flush", 32'(flush_o), 0);

      for (int v = 0; v < 16; v++) begin
         idle();
         pred_valid_i = 1'($urandom_range(0, 1));
         pred_pc_i = $urandom;
         res_pc_i = $urandom;
         res_valid_i = vecs[v].rv; res_cond_i = vecs[v].cond;
         res_a_i = vecs[v].a; res_b_i = vecs[v].b;
         res_pred_i = vecs[v].pred; exception_i = vecs[v].exc;
         cyc();
         chk($sformatf("vec%0d_taken", v), 32'(res_taken_o), 32'(vecs[v].e_taken));
         chk($sformatf("vec%0d_mis", v), 32'(mispredict_o), 32'(vecs[v].e_mis));
      end

      for (int n = 0; n < 400; n++) begin
         logic [31:0] hi;
         hi = $urandom & 32'hFFFFFF00;
         pred_valid_i = 1'($urandom_range(0, 1));
         pred_pc_i = hi | 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
         res_valid_i = 1'($urandom_range(0, 3) != 0);
         res_pc_i = ($urandom_range(0, 3) == 0) ? pred_pc_i
                    : (($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 63) << 2));
         res_cond_i = 3'($urandom_range(0, 7));
         res_a_i = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 4)) - 2);
         res_b_i = ($urandom_range(0, 1) == 1) ? res_a_i : $urandom;
         res_pred_i = 1'($urandom_range(0, 1));
         exception_i = ($urandom_range(0, 15) == 0);
         cyc();
      end

      // Statistics saturation, then reset in the middle of a mispredict burst.
      apply_reset();
      for (int k = 0; k < 20; k++) begin
         idle();
         set_res(32'(k * 4), 3'd6, 32'd0, 32'd0, 1'b0, 1'b0);
         cyc();
      end
      chk("t6_cnt_sat", 32'(mispred_cnt_o), 15);
      pred_valid_i = 1;
      @(posedge clk);
      model_edge();
      #2;
      chk("t6_pre_rst_mis", 32'(mispredict_o), 1);
      rst = 0;
      #1;
      check_zero("t6_async");
      idle();
      model_reset();
      @(negedge clk);
      rst = 1;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
